// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small receive FIFO.
// The line is resynchronised through two flops and then sampled by a baud
// counter. Completed bytes are queued in a power-of-two FIFO that the CPU pops
// through a valid/ready handshake. Framing errors and overruns are reported as
// registered single-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. A PARITY
// state then samples a ninth bit and parity_err reports mismatches; without the
// macro parity_err is tied low.
module uart_rx #(
  parameter int UART_CLK_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          rx_pin,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          framing_err,
  output logic                          overrun,
  output logic                          parity_err
);

  // Baud timing. CLKS_PER_BIT must be at least 2 so the half-bit point exists.
  localparam int CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int OCC_W        = PTR_W + 1;

  // Last counter value of a full bit period and of the first half of the start bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_EMPTY = {OCC_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Expected even-parity bit for a data byte: the XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // Input synchroniser
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic line_s;

  // Receive FSM and datapath
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic [7:0]       push_byte_q, push_byte_d;
  logic             framing_err_q, framing_err_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit_q, parity_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Receive FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             not_empty_s;
  logic             full_s;
  logic             pop_s;
  logic             accept_s;

  assign sync1_d = rx_pin;
  assign sync2_d = sync1_q;
  assign line_s  = sync2_q;

  // Two-flop resynchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Receive FSM state, baud counter, shift register and push request.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      push_q        <= 1'b0;
      push_byte_q   <= 8'h00;
      framing_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      push_q        <= push_d;
      push_byte_q   <= push_byte_d;
      framing_err_q <= framing_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q  <= parity_bit_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Next-state logic: centre-samples each bit and decides push or error at mid stop bit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push_d        = 1'b0;
    push_byte_d   = push_byte_q;
    framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d  = parity_bit_q;
    parity_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (!line_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // A start bit that is no longer low at its midpoint is a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          if (line_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {line_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = {CNT_W{1'b0}};
          parity_bit_d = line_s;
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        // Deciding at mid stop bit leaves half a bit to catch a back-to-back start.
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (line_s) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bit_q != even_parity(shift_q)) begin
              parity_err_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_byte_d = shift_q;
            end
`else
            push_d      = 1'b1;
            push_byte_d = shift_q;
`endif
          end else begin
            // A bad stop bit wins over a parity mismatch; only framing is flagged.
            framing_err_d = 1'b1;
            state_d       = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        // Hold off through a break until the line returns high.
        if (line_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FIFO handshake: a pop frees the head slot before a same-cycle push is judged.
  assign not_empty_s = (count_q != OCC_EMPTY);
  assign full_s      = (count_q == OCC_FULL);
  assign pop_s       = not_empty_s & rx_ready;
  assign accept_s    = push_q & (~full_s | pop_s);

  // FIFO pointer, occupancy and overrun next-state logic.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (accept_s) begin
      mem_d[wr_ptr_q] = push_byte_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    if (push_q && full_s && !pop_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = 1'b0;
    end
  end

  // FIFO storage and control registers; reset clears the storage as well.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= OCC_EMPTY;
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = not_empty_s;
  assign rx_count    = count_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=10, FIFO_DEPTH=4.
// Stimulus pushes expected bytes into exp_q; a negedge monitor pops and
// compares whenever the DUT hands over a byte and tallies status pulses.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // 2 sync + 5 start + 80 data + [10 parity] + 10 stop + 1 push
  localparam int EXP_LAT = 98 + CPB * (FB - 10);

  logic       clk;
  logic       n_reset;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       framing_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(
    .UART_CLK_HZ(1152000),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .framing_err(framing_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         start_cyc = 0;
  int         rise_cyc  = -1;
  int         fr_cnt    = 0;
  int         ov_cnt    = 0;
  int         pe_cnt    = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame bits, LSB first: start, data, [even parity], stop.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic stp);
`ifdef UART_RX_PARITY_EN
    return {1'b0, stp, ^d, d, 1'b0};
`else
    return {2'b00, stp, d, 1'b0};
`endif
  endfunction

  task automatic send_raw(input logic [11:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start_cyc = cyc;
      rx_pin = bits[i];
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_raw(mk_frame(d, 1'b1), FB);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_n(input int n);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  // cycle counter
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // monitor: pulse tallies, rx_valid rise time, pop scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1) begin
        if (framing_err === 1'b1) fr_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
        if (rx_valid === 1'b1 && prev_valid === 1'b0 && rise_cyc < 0) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no byte", rx_data);
          end else begin
            check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
          end
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] bad;
    n_reset  = 1'b0;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_count", 32'(rx_count), 32'h0);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_framing", 32'(framing_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_parity", 32'(parity_err), 32'h0);
    @(posedge clk);
    #1 n_reset = 1'b1;
    idle(5);

    // single frame, latency from the first edge that samples the low line
    exp_q.push_back(8'hA5);
    send_frame(8'hA5);
    idle(3);
    check("latency", 32'(rise_cyc - (start_cyc + 1)), 32'(EXP_LAT));
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_count", 32'(rx_count), 32'h1);
    check("a5_flags", 32'(fr_cnt + ov_cnt + pe_cnt), 32'h0);
    pop_n(1);
    idle(2);
    check("a5_drained", 32'(rx_count), 32'h0);

    // 3-cycle glitch is rejected
    @(posedge clk);
    #1 rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_pin = 1'b1;
    idle(20);
    check("glitch_count", 32'(rx_count), 32'h0);
    check("glitch_flags", 32'(fr_cnt + ov_cnt + pe_cnt), 32'h0);

    // bad stop bit, line held low, then a good frame
    send_raw(mk_frame(8'h3C, 1'b0), FB);
    repeat (40) @(posedge clk);
    #1 rx_pin = 1'b1;
    idle(10);
    check("framing_pulse", 32'(fr_cnt), 32'h1);
    check("framing_count", 32'(rx_count), 32'h0);
    exp_q.push_back(8'h55);
    send_frame(8'h55);
    idle(3);
    check("after_break_count", 32'(rx_count), 32'h1);
    pop_n(1);
    idle(2);

    // five frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i));
    end
    idle(5);
    check("full_count", 32'(rx_count), 32'h4);
    check("overrun_pulse", 32'(ov_cnt), 32'h1);
    check("full_head", 32'(rx_data), 32'h01);

    // push and pop in the same cycle while full
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77);
      begin
        @(posedge clk);
        repeat (CPB * FB - 2) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(5);
    check("pushpop_count", 32'(rx_count), 32'h4);
    check("pushpop_no_overrun", 32'(ov_cnt), 32'h1);
    pop_n(6);
    idle(2);
    check("drain_count", 32'(rx_count), 32'h0);
    check("drain_valid", 32'(rx_valid), 32'h0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'h0);

    // reset in the middle of a frame with two bytes queued
    exp_q.push_back(8'h11);
    send_frame(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h22);
    idle(3);
    check("queued_count", 32'(rx_count), 32'h2);
    send_raw(mk_frame(8'hC3, 1'b1), 4);
    #1;
    rx_pin  = 1'b1;
    n_reset = 1'b0;
    exp_q.delete();
    idle(1);
    check("midreset_valid", 32'(rx_valid), 32'h0);
    check("midreset_count", 32'(rx_count), 32'h0);
    check("midreset_data", 32'(rx_data), 32'h0);
    check("midreset_flags", 32'({framing_err, overrun, parity_err}), 32'h0);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;
    idle(10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A);
    idle(3);
    check("post_reset_count", 32'(rx_count), 32'h1);
    check("post_reset_data", 32'(rx_data), 32'h5A);
    pop_n(1);
    idle(2);
    check("post_reset_drained", 32'(rx_count), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit must be 1
    bad    = mk_frame(8'h07, 1'b1);
    bad[9] = ~bad[9];
    send_raw(bad, FB);
    idle(5);
    check("parity_err_pulse", 32'(pe_cnt), 32'h1);
    check("parity_err_count", 32'(rx_count), 32'h0);
    exp_q.push_back(8'h07);
    send_frame(8'h07);
    idle(3);
    check("parity_ok_count", 32'(rx_count), 32'h1);
    check("parity_ok_flags", 32'(pe_cnt), 32'h1);
    pop_n(1);
    idle(2);
`else
    bad = 12'h000;
    check("parity_tied_low", 32'(pe_cnt) | 32'(bad), 32'h0);
`endif
    check("framing_total", 32'(fr_cnt), 32'h1);
    check("overrun_total", 32'(ov_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-direction counterpart of the SoC's UART transmitter.
- Oversamples `rx_pin` with a baud counter, validates start and stop bits, and stores completed bytes in a small FIFO.
- The CPU bus pops the FIFO through a valid/ready interface.
- Reports framing errors and FIFO overruns as single-cycle pulses for the SoC status register.

Parameters:
- UART_CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. CLKS_PER_BIT = UART_CLK_HZ/BAUD_RATE (integer divide; 234 at defaults).
- FIFO_DEPTH, 4, receive FIFO entries. Must be a power of two and ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- rx_pin  input  1  asynchronous serial line; idles high.
- rx_data  output  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pops head when rx_valid & rx_ready.
- rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- framing_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while FIFO full and not popping.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without UART_RX_PARITY_EN.

Behaviour:
- Clock and reset: single clock `clk`. `n_reset` is asynchronous, active-low; every flop clears immediately on its assertion.
- Reset values:
  - rx_data=0 (FIFO storage cleared), rx_valid=0, rx_count=0.
  - framing_err=0, overrun=0, parity_err=0.
  - Synchronizer flops = 1; FSM = IDLE; baud counter, bit index and pointers = 0.
- Input sync: rx_pin passes through 2 flops; the FSM sees only the synced value, 2 cycles after the pin.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE: synced line low → START; counter=0.
- START: at counter = CLKS_PER_BIT/2 − 1, sample the line.
  - High → IDLE: glitch rejected, no flags.
  - Low → DATA; counter=0, bit index=0.
- DATA: every CLKS_PER_BIT cycles, sample into the shift register, LSB first. After bit 7 → STOP (PARITY with the macro).
- STOP: after CLKS_PER_BIT cycles, sample the line.
  - High: byte is pushed next cycle → IDLE. Sampling at mid stop bit allows back-to-back frames.
  - Low: framing_err pulses one cycle, byte discarded → WAIT_IDLE.
- WAIT_IDLE: stay until the synced line is high (break protection) → IDLE.
- Latency: rx_valid rises on the cycle after the stop-bit sample.
- FIFO:
  - rx_data = mem[rd_ptr], combinational from storage.
  - Pop on rx_valid & rx_ready.
  - Push when full and no pop: byte dropped, overrun pulses, FIFO unchanged.
  - Push and pop in the same cycle while full: pop first, push accepted, rx_count unchanged, no overrun.
  - Push and pop on a non-full FIFO: rx_count unchanged.
  - rx_ready with rx_valid=0: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: partial byte lost, FIFO emptied, FSM → IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN. With it defined, frame is 8E1.
  - PARITY state after DATA samples a ninth bit after CLKS_PER_BIT cycles, then → STOP.
  - In STOP, if the received parity bit ≠ XOR of the data bits: parity_err pulses one cycle and the byte is not pushed.
  - A valid stop bit is still required. If both parity and stop bit are bad, only framing_err pulses.
- Without it: 8N1, no PARITY state, parity_err tied 0.

Test Plan (UART_CLK_HZ=1152000, BAUD_RATE=115200 → CLKS_PER_BIT=10; FIFO_DEPTH=4):
- Frame 0xA5, rx_ready=0 → rx_valid=1, rx_data=0xA5, rx_count=1, exactly 2+5+80+10+1 = 98 cycles after the start falling edge; no flags.
- rx_pin low for 3 cycles then high → no push, no flags, FSM back in IDLE.
- Frame 0x3C with stop bit=0, line then held low 40 cycles then high, then frame 0x55 → framing_err single pulse, rx_count=0 after the first frame; 0x55 received, rx_count=1.
- Frames 0x01..0x05, rx_ready=0 → rx_count=4, overrun pulse at the 5th push; pops return 0x01,0x02,0x03,0x04, then rx_valid=0.
- FIFO full, rx_ready=1 held during 6th frame 0x77 → pop and push same cycle, no overrun, rx_count stays 4 until subsequent pops; 0x77 read last.
- n_reset asserted mid-DATA of 0xC3 with 2 bytes queued → all outputs at reset values; next frame 0x5A received correctly as sole entry.
- With UART_RX_PARITY_EN: frame 0x07 with parity=0 → parity_err pulse, no push; frame 0x07 with parity=1 → pushed.
